td4_core_param: RTL and testbench

- Parametrised successor of the TD4 4-bit CPU core: same two-register (A, B) accumulator machine and ISA, generalised to DATA_W-bit data and ADDR_W-bit program counter.
- Adds a ROM-ready fetch handshake (stall), an output strobe, a register-to-register ADD and a HALT state.
- Sits between the instruction ROM and board I/O; one instruction executes per accepted fetch.

---
 rtl/td4_core_param_if.sv | 24 ++
 rtl/td4_core_param.sv | 87 ++++++++
 tb/tb_td4_core_param.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/td4_core_param_if.sv
// Bus between the TD4-style core and its ROM / board I/O.
// The core attaches to the master modport; the ROM and I/O side attaches to the slave modport.
interface td4_core_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] IN_PORT;
  logic [DATA_W+3:0] ROM_DATA;
  logic              ROM_VALID;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] OUT_PORT;
  logic              OUT_STB;
  logic              HALTED;

  modport master (
    input  IN_PORT, ROM_DATA, ROM_VALID,
    output ROM_ADDR, OUT_PORT, OUT_STB, HALTED
  );

  modport slave (
    output IN_PORT, ROM_DATA, ROM_VALID,
    input  ROM_ADDR, OUT_PORT, OUT_STB, HALTED
  );
endinterface

// File: rtl/td4_core_param.sv
// Parametrised TD4 accumulator core.
// Executes one instruction per edge on which ROM_VALID is high, and stops in HALT until CLR.
module td4_core_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  td4_core_param_if.master    bus
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t            st, st_n;
  logic [DATA_W-1:0] a, a_n, b, b_n, out_q, out_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              c, c_n, stb, stb_n;
  logic [3:0]        op;
  logic [DATA_W-1:0] im;
  logic              vld_p0;

  function automatic logic [DATA_W:0] add_c(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  assign op     = bus.ROM_DATA[DATA_W +: 4];
  assign im     = bus.ROM_DATA[DATA_W-1:0];
  assign vld_p0 = (st == ST_RUN) && bus.ROM_VALID;

  always_comb begin
    st_n  = st;
    a_n   = a;
    b_n   = b;
    c_n   = c;
    pc_n  = pc;
    out_n = out_q;
    stb_n = 1'b0;
    if (vld_p0) begin
      // Any executed instruction clears carry unless it is an ADD.
      c_n  = 1'b0;
      pc_n = pc + ADDR_W'(1);
      case (op)
        4'b0000: {c_n, a_n} = add_c(a, im);
        4'b0101: {c_n, b_n} = add_c(b, im);
        4'b1000: {c_n, a_n} = add_c(a, b);
        4'b0011: a_n = im;
        4'b0111: b_n = im;
        4'b0001: a_n = b;
        4'b0100: b_n = a;
        4'b0010: a_n = bus.IN_PORT;
        4'b0110: b_n = bus.IN_PORT;
        4'b1001: begin out_n = b;  stb_n = 1'b1; end
        4'b1011: begin out_n = im; stb_n = 1'b1; end
        4'b1111: pc_n = ADDR_W'(im);
        4'b1110: if (!c) pc_n = ADDR_W'(im);
        4'b1101: begin pc_n = pc; st_n = ST_HALT; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      st    <= ST_RUN;
      a     <= '0;
      b     <= '0;
      c     <= 1'b0;
      pc    <= '0;
      out_q <= '0;
      stb   <= 1'b0;
    end else begin
      st    <= st_n;
      a     <= a_n;
      b     <= b_n;
      c     <= c_n;
      pc    <= pc_n;
      out_q <= out_n;
      stb   <= stb_n;
    end
  end

  assign bus.ROM_ADDR = pc;
  assign bus.OUT_PORT = out_q;
  assign bus.OUT_STB  = stb;
  assign bus.HALTED   = (st == ST_HALT);

endmodule

// File: tb/tb_td4_core_param.sv
// Bench for td4_core_param at 4/4 and 8/6 widths against an arithmetic reference model.
module tb_td4_core_param;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  td4_core_param_if #(.DATA_W(4), .ADDR_W(4)) bus4 ();
  td4_core_param_if #(.DATA_W(8), .ADDR_W(6)) bus8 ();

  td4_core_param #(.DATA_W(4), .ADDR_W(4)) dut4 (.CLK(clk), .CLR(clr), .bus(bus4));
  td4_core_param #(.DATA_W(8), .ADDR_W(6)) dut8 (.CLK(clk), .CLR(clr), .bus(bus8));

  int checks = 0;
  int failures = 0;

  int dw [2] = '{4, 8};
  int aw [2] = '{4, 6};
  int ma [2], mb [2], mc [2], mpc [2], mout [2], mstb [2], mhalt [2];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: one clock edge of the ISA, in plain integer arithmetic.
  task automatic model(input int k, input bit r, input bit v, input int op, input int im, input int inp);
    int dm, am, s, oldc;
    dm = (1 << dw[k]) - 1;
    am = (1 << aw[k]) - 1;
    if (r) begin
      ma[k] = 0; mb[k] = 0; mc[k] = 0; mpc[k] = 0; mout[k] = 0; mstb[k] = 0; mhalt[k] = 0;
      return;
    end
    mstb[k] = 0;
    if (mhalt[k] != 0 || !v) return;
    oldc = mc[k];
    mc[k] = 0;
    mpc[k] = (mpc[k] + 1) & am;
    case (op)
      0:  begin s = ma[k] + im;    mc[k] = (s > dm); ma[k] = s & dm; end
      5:  begin s = mb[k] + im;    mc[k] = (s > dm); mb[k] = s & dm; end
      8:  begin s = ma[k] + mb[k]; mc[k] = (s > dm); ma[k] = s & dm; end
      3:  ma[k] = im;
      7:  mb[k] = im;
      1:  ma[k] = mb[k];
      4:  mb[k] = ma[k];
      2:  ma[k] = inp;
      6:  mb[k] = inp;
      9:  begin mout[k] = mb[k]; mstb[k] = 1; end
      11: begin mout[k] = im;    mstb[k] = 1; end
      15: mpc[k] = im & am;
      14: if (oldc == 0) mpc[k] = im & am;
      13: begin mpc[k] = (mpc[k] - 1) & am; mhalt[k] = 1; end
      default: ;
    endcase
  endtask

  task automatic compare(input int k);
    int oa, ob, oc, opc, oout, ostb, ohalt;
    string p;
    if (k == 0) begin
      oa = int'(dut4.a); ob = int'(dut4.b); oc = int'(dut4.c);
      opc = int'(bus4.ROM_ADDR); oout = int'(bus4.OUT_PORT);
      ostb = int'(bus4.OUT_STB); ohalt = int'(bus4.HALTED);
      p = "w4";
    end else begin
      oa = int'(dut8.a); ob = int'(dut8.b); oc = int'(dut8.c);
      opc = int'(bus8.ROM_ADDR); oout = int'(bus8.OUT_PORT);
      ostb = int'(bus8.OUT_STB); ohalt = int'(bus8.HALTED);
      p = "w8";
    end
    check({p, "_a"}, oa, ma[k]);
    check({p, "_b"}, ob, mb[k]);
    check({p, "_c"}, oc, mc[k]);
    check({p, "_pc"}, opc, mpc[k]);
    check({p, "_out"}, oout, mout[k]);
    check({p, "_stb"}, ostb, mstb[k]);
    check({p, "_halted"}, ohalt, mhalt[k]);
  endtask

  // Drive one instruction into instance k (the other instance stalls), clock once, compare both.
  task automatic step(input int k, input bit r, input bit v, input int op, input int im, input int inp);
    clr = r;
    bus4.ROM_VALID = (k == 0) ? v : 1'b0;
    bus8.ROM_VALID = (k == 1) ? v : 1'b0;
    if (k == 0) begin
      bus4.ROM_DATA = 8'(((op & 15) << 4) | (im & 15));
      bus4.IN_PORT  = 4'(inp);
    end else begin
      bus8.ROM_DATA = 12'(((op & 15) << 8) | (im & 255));
      bus8.IN_PORT  = 8'(inp);
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++)
      model(j, r, (j == k) ? v : 1'b0, op & 15, im & ((1 << dw[j]) - 1), inp & ((1 << dw[j]) - 1));
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    bus4.ROM_VALID = 1'b0; bus4.ROM_DATA = '0; bus4.IN_PORT = '0;
    bus8.ROM_VALID = 1'b0; bus8.ROM_DATA = '0; bus8.IN_PORT = '0;
    #1;

    // Reset state, then reset in the middle of a run.
    step(0, 1, 0, 0, 0, 0);
    check("rst_pc", int'(bus4.ROM_ADDR), 0);
    step(0, 0, 1, 3, 7, 0);
    check("mov_a7", int'(dut4.a), 7);
    step(0, 1, 1, 3, 5, 0);
    check("clr_a", int'(dut4.a), 0);

    // Carry and JNC.
    step(0, 0, 1, 3, 3, 0);
    step(0, 0, 1, 0, 14, 0);
    check("add_carry", int'(dut4.c), 1);
    check("add_wrap", int'(dut4.a), 1);
    step(0, 0, 1, 14, 0, 0);
    check("jnc_fall", int'(bus4.ROM_ADDR), 3);
    step(0, 0, 1, 14, 9, 0);
    check("jnc_taken", int'(bus4.ROM_ADDR), 9);

    // Stall on ADD B,1 with B=15.
    step(0, 0, 1, 7, 15, 0);
    repeat (3) step(0, 0, 0, 5, 1, 0);
    step(0, 0, 1, 5, 1, 0);
    check("stall_add_b", int'(dut4.b), 0);
    check("stall_add_c", int'(dut4.c), 1);

    // Output strobe sequence.
    step(0, 0, 1, 6, 0, 10);
    step(0, 0, 1, 9, 0, 0);
    check("out_b", int'(bus4.OUT_PORT), 10);
    check("out_b_stb", int'(bus4.OUT_STB), 1);
    step(0, 0, 1, 11, 5, 0);
    check("out_im", int'(bus4.OUT_PORT), 5);
    check("out_im_stb", int'(bus4.OUT_STB), 1);
    step(0, 0, 1, 10, 0, 0);
    check("stb_drop", int'(bus4.OUT_STB), 0);

    // PC wrap, HALT, release by CLR.
    step(0, 0, 1, 15, 15, 0);
    step(0, 0, 1, 10, 0, 0);
    check("pc_wrap", int'(bus4.ROM_ADDR), 0);
    step(0, 0, 1, 13, 0, 0);
    repeat (10) step(0, 0, 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    check("halt_pc", int'(bus4.ROM_ADDR), 0);
    check("halt_flag", int'(bus4.HALTED), 1);
    step(0, 1, 0, 0, 0, 0);
    check("halt_clr", int'(bus4.HALTED), 0);

    // Wider configuration.
    step(1, 0, 1, 3, 8'hC8, 0);
    step(1, 0, 1, 7, 8'h64, 0);
    step(1, 0, 1, 8, 0, 0);
    check("w8_add_ab", int'(dut8.a), 8'h2C);
    check("w8_add_c", int'(dut8.c), 1);
    step(1, 0, 1, 15, 8'hFF, 0);
    check("w8_jmp_trunc", int'(bus8.ROM_ADDR), 6'h3F);

    // Random instruction streams on both instances.
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 1);
      step(k, ($urandom_range(0, 24) == 0), ($urandom_range(0, 4) != 0),
           $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
